sum_window_stats: RTL and testbench

- Downstream consumer of the registered 5-bit operand-sum stream produced by the adder stage.
- Collects a fixed window of WIN sum samples over a valid/ready handshake.
- Per window, reports total, minimum, maximum and truncated mean on a held valid/ready result port.
- Feeds the output mux/readout logic; the design's aggregation stage between the adder and the pins.

---
 rtl/sum_window_stats.sv | 140 ++++++++++++++
 tb/tb_sum_window_stats.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sum_window_stats.sv
`default_nettype none
// ============================================================================
// Module      : sum_window_stats
// Description : Collects WIN unsigned sum samples over a valid/ready handshake
//               and reports the window total, minimum, maximum and truncated
//               mean on a held valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_window_stats #(
    parameter  int DATA_W  = 5,
    parameter  int WIN     = 8,
    localparam int LOG_WIN = $clog2(WIN),
    localparam int SUM_W   = DATA_W + LOG_WIN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SUM_W-1:0]   res_sum,
    output logic [DATA_W-1:0]  res_min,
    output logic [DATA_W-1:0]  res_max,
    output logic [DATA_W-1:0]  res_mean,
    output logic [LOG_WIN-1:0] fill_cnt
);

    localparam logic [LOG_WIN-1:0] LAST_IDX = LOG_WIN'(WIN - 1);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [SUM_W-1:0]  acc_sum;
    logic [DATA_W-1:0] acc_min;
    logic [DATA_W-1:0] acc_max;

    logic              accept;
    logic              closing;
    logic [SUM_W-1:0]  sum_next;
    logic [DATA_W-1:0] min_next;
    logic [DATA_W-1:0] max_next;

    // in_ready is only high in ACCUM, so it alone qualifies an accept
    assign accept   = in_valid & in_ready;
    assign closing  = accept && (fill_cnt == LAST_IDX);
    assign sum_next = acc_sum + SUM_W'(in_data);

    // Running min/max including the sample on in_data; first sample seeds both
    always_comb begin
        min_next = acc_min;
        max_next = acc_max;
        if (fill_cnt == '0) begin
            min_next = in_data;
            max_next = in_data;
        end else begin
            if (in_data < acc_min) min_next = in_data;
            if (in_data > acc_max) max_next = in_data;
        end
    end

    // State register; clear forces ACCUM ahead of any handshake event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     state <= ACCUM;
        else if (clear) state <= ACCUM;
        else            state <= state_next;
    end

    // Next-state: close a window into HOLD, leave HOLD when the result is taken
    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (closing)   state_next = HOLD;
            HOLD:    if (out_ready) state_next = ACCUM;
            default:                state_next = ACCUM;
        endcase
    end

    // Handshake flags are registered copies of the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next == ACCUM);
            out_valid <= (state_next == HOLD);
        end
    end

    // Accumulators and fill count; a closing accept rewinds them for the next window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum  <= '0;
            acc_min  <= '0;
            acc_max  <= '0;
            fill_cnt <= '0;
        end else if (clear || closing) begin
            acc_sum  <= '0;
            acc_min  <= '0;
            acc_max  <= '0;
            fill_cnt <= '0;
        end else if (accept) begin
            acc_sum  <= sum_next;
            acc_min  <= min_next;
            acc_max  <= max_next;
            fill_cnt <= fill_cnt + LOG_WIN'(1);
        end
    end

    // Result registers load on a closing accept and otherwise hold their value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_sum  <= '0;
            res_min  <= '0;
            res_max  <= '0;
            res_mean <= '0;
        end else if (clear) begin
            res_sum  <= '0;
            res_min  <= '0;
            res_max  <= '0;
            res_mean <= '0;
        end else if (closing) begin
            res_sum  <= sum_next;
            res_min  <= min_next;
            res_max  <= max_next;
            res_mean <= sum_next[SUM_W-1:LOG_WIN];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sum_window_stats.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_window_stats
// Description : Directed scoreboard bench for sum_window_stats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_window_stats;

    localparam int DATA_W  = 5;
    localparam int WIN     = 8;
    localparam int LOG_WIN = 3;
    localparam int SUM_W   = DATA_W + LOG_WIN;

    logic               clk;
    logic               rst_n;
    logic               clear;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [SUM_W-1:0]   res_sum;
    logic [DATA_W-1:0]  res_min;
    logic [DATA_W-1:0]  res_max;
    logic [DATA_W-1:0]  res_mean;
    logic [LOG_WIN-1:0] fill_cnt;

    sum_window_stats #(.DATA_W(DATA_W), .WIN(WIN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_sum   (res_sum),
        .res_min   (res_min),
        .res_max   (res_max),
        .res_mean  (res_mean),
        .fill_cnt  (fill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int mn;
        int mx;
        int mean;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference window model
    int m_cnt = 0;
    int m_sum = 0;
    int m_min = 0;
    int m_max = 0;

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endfunction

    function automatic void model_reset();
        m_cnt = 0;
        m_sum = 0;
        m_min = 0;
        m_max = 0;
    endfunction

    // Offer one sample; waits (bounded) for in_ready, updates the model
    // before the accepting edge so the expectation is queued in time.
    task automatic send(input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_wait", 32'(n < 50), 32'd1);
        if (m_cnt == 0) begin
            m_min = int'(d);
            m_max = int'(d);
        end else begin
            if (int'(d) < m_min) m_min = int'(d);
            if (int'(d) > m_max) m_max = int'(d);
        end
        m_sum += int'(d);
        m_cnt++;
        if (m_cnt == WIN) begin
            exp_t e;
            e.sum  = m_sum;
            e.mn   = m_min;
            e.mx   = m_max;
            e.mean = m_sum / WIN;
            exp_q.push_back(e);
            model_reset();
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("fill_cnt", 32'(fill_cnt), 32'(m_cnt));
    endtask

    // Result monitor: pop and compare once per out_valid assertion
    bit seen = 1'b0;
    always @(negedge clk) begin
        if (out_valid === 1'b1 && !seen) begin
            seen = 1'b1;
            check("result_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_sum",  32'(res_sum),  32'(e.sum));
                check("res_min",  32'(res_min),  32'(e.mn));
                check("res_max",  32'(res_max),  32'(e.mx));
                check("res_mean", 32'(res_mean), 32'(e.mean));
            end
        end else if (out_valid !== 1'b1) begin
            seen = 1'b0;
        end
    end

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // ---------------- reset ----------------
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready",  32'(in_ready),  32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_res_sum",   32'(res_sum),   32'd0);
            check("rst_res_max",   32'(res_max),   32'd0);
            check("rst_fill_cnt",  32'(fill_cnt),  32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // ---------------- ascending window ----------------
        out_ready = 1'b1;
        for (int i = 0; i < WIN; i++) send(DATA_W'(i));
        check("asc_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("asc_out_valid_drop", 32'(out_valid), 32'd0);
        check("asc_in_ready_back",  32'(in_ready),  32'd1);
        check("asc_res_persist",    32'(res_sum),   32'd28);

        // ---------------- max values with gaps ----------------
        for (int i = 0; i < WIN; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(5'd31);
        end
        @(negedge clk);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        send(5'd5);  send(5'd9); send(5'd2); send(5'd30);
        send(5'd17); send(5'd2); send(5'd0); send(5'd11);
        in_valid = 1'b1;
        in_data  = 5'd25;
        repeat (6) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_res_sum",   32'(res_sum),   32'd76);
            check("bp_res_min",   32'(res_min),   32'd0);
            check("bp_res_max",   32'(res_max),   32'd30);
            check("bp_res_mean",  32'(res_mean),  32'd9);
            check("bp_fill_cnt",  32'(fill_cnt),  32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready",  32'(in_ready),  32'd1);
        check("bp_release_fill_cnt",  32'(fill_cnt),  32'd0);
        for (int i = 0; i < WIN; i++) send(DATA_W'(i * 3));
        @(negedge clk);

        // ---------------- clear mid-window ----------------
        repeat (3) send(5'd20);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 5'd20;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        check("clr_fill_cnt",  32'(fill_cnt),  32'd0);
        check("clr_in_ready",  32'(in_ready),  32'd1);
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_res_sum",   32'(res_sum),   32'd0);
        check("clr_res_max",   32'(res_max),   32'd0);
        repeat (WIN) send(5'd2);
        @(negedge clk);

        // ---------------- reset during HOLD ----------------
        out_ready = 1'b0;
        for (int i = 1; i <= WIN; i++) send(DATA_W'(i));
        check("hold_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_in_ready",  32'(in_ready),  32'd0);
        check("async_res_sum",   32'(res_sum),   32'd0);
        check("async_res_min",   32'(res_min),   32'd0);
        check("async_res_max",   32'(res_max),   32'd0);
        check("async_res_mean",  32'(res_mean),  32'd0);
        check("async_fill_cnt",  32'(fill_cnt),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
